// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch front-end.
//   XLEN             datapath width
//   RESET_PC_DEFAULT default PC loaded on reset
//   INSTR_NOP        canonical no-op encoding (addi x0,x0,0)
//   fetch_entry_t    one queue entry: fetched word plus the PC it came from
//   word_align()     clears the byte-offset bits of an address
`timescale 1ns/1ps
package instruction_fetch_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_queue.sv
// fetch_queue: synchronous FIFO holding {instr, pc} entries between the ROM
// response and decode.
//   clk, rst_n  clock / async active-low reset
//   push, din   write an entry (ignored while flush is high)
//   pop         consume the head entry
//   flush       discard all entries; pop of the same cycle still counts as taken
//   full, empty occupancy flags
//   count       number of valid entries
//   head        entry at the read pointer (undefined contents when empty)
`timescale 1ns/1ps
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNTW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the slot a same-cycle push lands in, so full+pop+push is legal.
  assign do_push = push & (~full | do_pop);
  assign count   = cnt;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register and sequential read issue to a synchronous
// instruction ROM (1-cycle latency), response queue, valid/ready to decode,
// and redirect (branch/jump) handling.
//   clk             system clock
//   btn2            async active-low reset
//   rom_rd_en       read strobe, rom_addr sampled on the same edge
//   rom_addr        word-aligned read address (= pc)
//   rom_data        ROM word, valid the cycle after a sampled read
//   redirect_valid  one-cycle pulse: flush and restart at redirect_pc
//   redirect_pc     redirect target (low two bits forced to zero)
//   instr_valid     head of queue holds a valid instruction
//   instr, instr_pc head instruction and its PC (zero when invalid)
//   instr_ready     decode accepts the head this cycle
`timescale 1ns/1ps
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int              QUEUE_DEPTH = 2
) (
  input  logic            clk,
  input  logic            btn2,
  output logic            rom_rd_en,
  output logic [XLEN-1:0] rom_addr,
  input  logic [XLEN-1:0] rom_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int OW = CW + 1;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic            req_epoch;
  logic            epoch;

  logic [CW-1:0]   q_count;
  logic            q_full;
  logic            q_empty;
  fetch_entry_t    q_head;
  fetch_entry_t    push_entry;
  logic            pop;
  logic            resp_ok;
  logic            push;
  logic [OW-1:0]   occupancy;
  logic            issue_ok;

  assign instr_valid = ~q_empty;
  assign pop         = instr_valid & instr_ready;

  // Entries left after this cycle's pop plus the response already on its way
  // must leave room for the word about to be requested.
  assign occupancy = {1'b0, q_count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, inflight};
  assign issue_ok  = (occupancy < OW'(QUEUE_DEPTH));

  // btn2 gating keeps the strobe low while reset is held.
  assign rom_rd_en = btn2 & ~redirect_valid & issue_ok;
  assign rom_addr  = pc;

  // Responses tagged with an older epoch belong to a discarded fetch stream.
  assign resp_ok = inflight & (req_epoch == epoch);
  assign push    = resp_ok & (~q_full | pop);

  assign push_entry.instr = rom_data;
  assign push_entry.pc    = req_pc;

  assign instr    = q_empty ? '0 : q_head.instr;
  assign instr_pc = q_empty ? '0 : q_head.pc;

  always_ff @(posedge clk or negedge btn2) begin
    if (!btn2) begin
      pc        <= RESET_PC;
      req_pc    <= '0;
      inflight  <= 1'b0;
      req_epoch <= 1'b0;
      epoch     <= 1'b0;
    end else begin
      inflight <= rom_rd_en;
      if (rom_rd_en) begin
        req_pc    <= pc;
        req_epoch <= epoch;
      end
      if (redirect_valid) begin
        pc    <= word_align(redirect_pc);
        epoch <= ~epoch;
      end else if (rom_rd_en) begin
        pc <= pc + 32'd4;
      end
    end
  end

  fetch_queue #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (btn2),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count),
    .head  (q_head)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
`timescale 1ns/100ps
module tb_instruction_fetch;

  logic        clk  = 1'b0;
  logic        btn2 = 1'b1;

  logic        rom_rd_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  logic        w_rom_rd_en;
  logic [31:0] w_rom_addr;
  logic [31:0] w_rom_data = 32'h0;
  logic        w_instr_valid;
  logic [31:0] w_instr;
  logic [31:0] w_instr_pc;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic        w_instr_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  logic        arm      = 1'b0;
  logic        mon_en   = 1'b0;
  logic        vis_en   = 1'b0;
  logic [31:0] vis_pc   = 32'h0;
  logic        ovf_seen = 1'b0;
  int          acc4_count = 0;
  int          vis_hits   = 0;
  int          pulses;
  logic [31:0] wexp;

  always #1 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) dut (
    .clk            (clk),
    .btn2           (btn2),
    .rom_rd_en      (rom_rd_en),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(2)) wdut (
    .clk            (clk),
    .btn2           (btn2),
    .rom_rd_en      (w_rom_rd_en),
    .rom_addr       (w_rom_addr),
    .rom_data       (w_rom_data),
    .redirect_valid (w_redirect_valid),
    .redirect_pc    (w_redirect_pc),
    .instr_valid    (w_instr_valid),
    .instr          (w_instr),
    .instr_pc       (w_instr_pc),
    .instr_ready    (w_instr_ready)
  );

  // addi x1,x0,imm with imm taken from the word index, so every address has a distinct word
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[13:2], 5'd0, 3'b000, 5'd1, 7'h13};
  endfunction

  always @(posedge clk) begin
    if (rom_rd_en)   rom_data   <= rom_word(rom_addr);
    if (w_rom_rd_en) w_rom_data <= rom_word(w_rom_addr);
  end

  always @(posedge clk) begin
    if (arm && btn2 &&
        ((dut.resp_ok && dut.q_full && !dut.pop) ||
         (wdut.resp_ok && wdut.q_full && !wdut.pop)))
      ovf_seen <= 1'b1;
    if (mon_en && instr_valid && instr_ready && instr_pc == 32'h4)
      acc4_count <= acc4_count + 1;
    if (vis_en && instr_valid && instr_pc == vis_pc)
      vis_hits <= vis_hits + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse btn2 low for one time unit between edges; checks the reset-state outputs.
  task automatic do_reset();
    @(negedge clk);
    #0.5 btn2 = 1'b0;
    #0.3;
    check("rst_valid",    instr_valid, 0);
    check("rst_rd_en",    rom_rd_en,   0);
    check("rst_addr",     rom_addr,    32'h0);
    check("rst_instr",    instr,       32'h0);
    check("rst_instr_pc", instr_pc,    32'h0);
    check("rst_w_addr",   w_rom_addr,  32'hFFFF_FFF8);
    check("rst_w_valid",  w_instr_valid, 0);
    #0.7 btn2 = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog timeout");
  end

  initial begin
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset latency, sequential stream, and wrap-around instance
    do_reset();
    arm = 1'b1;
    tick();
    check("t1_valid_edge1", instr_valid, 0);
    check("t1_rd_en_edge1", rom_rd_en, 1);
    check("t5_valid_edge1", w_instr_valid, 0);
    tick();
    wexp = 32'hFFFF_FFF8;
    for (int i = 0; i < 6; i++) begin
      check("t1_valid", instr_valid, 1);
      check("t1_pc",    instr_pc, 32'(4*i));
      check("t1_instr", instr, rom_word(32'(4*i)));
      check("t5_valid", w_instr_valid, 1);
      check("t5_pc",    w_instr_pc, wexp);
      check("t5_instr", w_instr, rom_word(wexp));
      wexp = wexp + 32'd4;
      tick();
    end

    // Back-pressure: head stays put, few reads issued, nothing lost on resume
    instr_ready = 1'b0;
    pulses = 0;
    #0.1;
    for (int i = 0; i < 5; i++) begin
      if (rom_rd_en) pulses++;
      tick();
      check("t2_hold_valid", instr_valid, 1);
      check("t2_hold_pc",    instr_pc, 32'd24);
      check("t2_hold_instr", instr, rom_word(32'd24));
    end
    check("t2_rd_pulses_le2", 32'(pulses <= 2), 1);
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_resume_valid", instr_valid, 1);
      check("t2_resume_pc",    instr_pc, 32'(24 + 4*i));
      check("t2_resume_instr", instr, rom_word(32'(24 + 4*i)));
      tick();
    end

    // Redirect to 0x40 while the read of 0x8 is in flight
    do_reset();
    tick();
    tick();
    tick();
    check("t3_pre_pc", instr_pc, 32'h4);
    vis_pc = 32'h8;
    vis_en = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #0.1;
    check("t3_rd_en_redirect", rom_rd_en, 0);
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    check("t3_gap1_valid", instr_valid, 0);
    tick();
    check("t3_gap2_valid", instr_valid, 0);
    check("t3_gap2_addr_seq", rom_addr, 32'h44);
    tick();
    check("t3_tgt_valid", instr_valid, 1);
    check("t3_tgt_pc",    instr_pc, 32'h40);
    check("t3_tgt_instr", instr, rom_word(32'h40));
    tick();
    check("t3_next_pc", instr_pc, 32'h44);
    vis_en = 1'b0;
    check("t3_stale_8_seen", 32'(vis_hits), 0);

    // Redirect to 0x43 in the same cycle as the handshake of pc 0x4
    do_reset();
    mon_en = 1'b1;
    tick();
    tick();
    tick();
    check("t4_pre_pc", instr_pc, 32'h4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    instr_ready    = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("t4_gap1_valid", instr_valid, 0);
    tick();
    check("t4_gap2_valid", instr_valid, 0);
    tick();
    check("t4_tgt_valid", instr_valid, 1);
    check("t4_tgt_pc",    instr_pc, 32'h40);
    tick();
    check("t4_next_pc", instr_pc, 32'h44);
    tick();
    mon_en = 1'b0;
    check("t4_pc4_accepts", 32'(acc4_count), 1);

    // Reset mid-stream with a read in flight
    check("t6_pre_rd_inflight", dut.inflight, 1);
    do_reset();
    tick();
    check("t6_valid_edge1", instr_valid, 0);
    tick();
    check("t6_first_valid", instr_valid, 1);
    check("t6_first_pc",    instr_pc, 32'h0);
    check("t6_first_instr", instr, rom_word(32'h0));
    tick();
    check("t6_second_pc", instr_pc, 32'h4);

    check("queue_overflow", ovf_seen, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
